// File: rtl/corner_tracker_pkg.sv
// Shared types for the corner tracker: corner index, FSM states, default corner set.
// Build option: CORNER_FALLBACK_EN selects the fallback corner set (else all zeros).
package corner_pkg;

   typedef enum logic [1:0] {
      CI_TL = 2'd0,
      CI_TR = 2'd1,
      CI_BL = 2'd2,
      CI_BR = 2'd3
   } corner_idx_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   // Widest coordinate the default-corner helper can describe.
   localparam int CORNER_MAX_W = 16;

   localparam int DEF_LEFT_X  = 192;
   localparam int DEF_RIGHT_X = 832;
   localparam int DEF_TOP_Y   = 144;
   localparam int DEF_BOT_Y   = 624;

   typedef struct packed {
      logic [CORNER_MAX_W-1:0] x;
      logic [CORNER_MAX_W-1:0] y;
   } corner_t;

   // Corner reported when a frame has too few hits (and at reset).
   function automatic corner_t default_corner(corner_idx_e idx);
      corner_t c;
      c = '0;
`ifdef CORNER_FALLBACK_EN
      c.x = CORNER_MAX_W'((idx == CI_TL || idx == CI_BL) ? DEF_LEFT_X : DEF_RIGHT_X);
      c.y = CORNER_MAX_W'((idx == CI_TL || idx == CI_TR) ? DEF_TOP_Y : DEF_BOT_Y);
`else
      c.x = (idx == CI_TL) ? '0 : '0;
`endif
      return c;
   endfunction

endpackage

// File: rtl/corner_tracker_if.sv
// Pixel stream from the frame-buffer reader: valid/ready handshake, raster order.
interface corner_tracker_if #(
   parameter int PIX_W = 8
);
   logic [PIX_W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;

   modport master (output pix_data, output pix_valid, input pix_ready);
   modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/corner_tracker_tracker.sv
// extreme_tracker: holds the best metric seen since the last clear, with its x,y.
// Only a strict improvement replaces the held value, so the earliest pixel wins ties.
module extreme_tracker #(
   parameter int COORD_W = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      hit,
   input  logic                      mode_max,
   input  logic signed [COORD_W+1:0] metric,
   input  logic [COORD_W-1:0]        x,
   input  logic [COORD_W-1:0]        y,
   output logic signed [COORD_W+1:0] best_metric,
   output logic [COORD_W-1:0]        best_x,
   output logic [COORD_W-1:0]        best_y,
   output logic                      seen
);
   logic signed [COORD_W+1:0] best_q, best_d;
   logic [COORD_W-1:0]        bx_q, bx_d, by_q, by_d;
   logic                      seen_q, seen_d;
   logic                      better;

   // Next held value: clear wins, the first hit seeds, later hits need strict improvement.
   always_comb begin
      best_d = best_q;
      bx_d   = bx_q;
      by_d   = by_q;
      seen_d = seen_q;
      better = mode_max ? (metric > best_q) : (metric < best_q);
      if (clear) begin
         best_d = '0;
         bx_d   = '0;
         by_d   = '0;
         seen_d = 1'b0;
      end else if (hit && (!seen_q || better)) begin
         best_d = metric;
         bx_d   = x;
         by_d   = y;
         seen_d = 1'b1;
      end
   end

   // Tracker state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_q <= '0;
         bx_q   <= '0;
         by_q   <= '0;
         seen_q <= 1'b0;
      end else begin
         best_q <= best_d;
         bx_q   <= bx_d;
         by_q   <= by_d;
         seen_q <= seen_d;
      end
   end

   assign best_metric = best_q;
   assign best_x      = bx_q;
   assign best_y      = by_q;
   assign seen        = seen_q;

endmodule

// File: rtl/corner_tracker.sv
// corner_tracker: scans one raster frame, thresholds pixels into hits and reports the
// four extreme hits packed {TLx,TLy,TRx,TRy,BLx,BLy,BRx,BRy}.
// Build option: CORNER_FALLBACK_EN makes too-sparse frames report the fallback corner set.
module corner_tracker
   import corner_pkg::*;
#(
   parameter int COORD_W  = 10,
   parameter int H_ACTIVE = 1024,
   parameter int V_ACTIVE = 768,
   parameter int PIX_W    = 8,
   parameter int MIN_HITS = 1,
   parameter int CNT_W    = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [PIX_W-1:0]       thresh,
   corner_tracker_if.slave        pix,
   output logic                   busy,
   output logic                   done,
   output logic                   corners_valid,
   output logic [CNT_W-1:0]       hit_count,
   output logic [8*COORD_W-1:0]   corners
);
   localparam int MW = COORD_W + 2;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_HITS);

   function automatic logic [8*COORD_W-1:0] default_set();
      logic [8*COORD_W-1:0] s;
      corner_t              c;
      s = '0;
      for (int i = 0; i < 4; i++) begin
         c = default_corner(corner_idx_e'(i));
         s[(7-2*i)*COORD_W +: COORD_W] = c.x[COORD_W-1:0];
         s[(6-2*i)*COORD_W +: COORD_W] = c.y[COORD_W-1:0];
      end
      return s;
   endfunction

   localparam logic [8*COORD_W-1:0] DEF_SET = default_set();

   state_e                state_q, state_d;
   logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
   logic [PIX_W-1:0]      thr_q, thr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d, ready_q, ready_d, done_q, done_d;
   logic                  cval_q, cval_d;
   logic [CNT_W-1:0]      hcnt_q, hcnt_d;
   logic [8*COORD_W-1:0]  corners_q, corners_d;

   logic                  clr, xfer, is_hit;
   logic signed [MW-1:0]  m_sum, m_xy, m_yx;
   logic [3:0][COORD_W-1:0] trk_x, trk_y;
   logic [3:0][MW-1:0]      unused_metric;
   logic [3:0]              trk_seen;

   // A start in SCAN aborts; any pixel handed over in that same cycle belongs to the
   // abandoned frame and is dropped.
   assign xfer   = (state_q == ST_SCAN) && pix.pix_valid && ready_q && !start;
   assign is_hit = xfer && (pix.pix_data >= thr_q);

   assign m_sum = $signed({2'b00, x_q}) + $signed({2'b00, y_q});
   assign m_xy  = $signed({2'b00, x_q}) - $signed({2'b00, y_q});
   assign m_yx  = $signed({2'b00, y_q}) - $signed({2'b00, x_q});

   for (genvar gi = 0; gi < 4; gi++) begin : g_trk
      localparam corner_idx_e IDX = corner_idx_e'(gi);
      logic signed [MW-1:0] metric;
      assign metric = (IDX == CI_TR) ? m_xy : (IDX == CI_BL) ? m_yx : m_sum;

      extreme_tracker #(.COORD_W(COORD_W)) u_trk (
         .clk         (clk),
         .rst_n       (rst_n),
         .clear       (clr),
         .hit         (is_hit),
         .mode_max    (IDX != CI_TL),
         .metric      (metric),
         .x           (x_q),
         .y           (y_q),
         .best_metric (unused_metric[gi]),
         .best_x      (trk_x[gi]),
         .best_y      (trk_y[gi]),
         .seen        (trk_seen[gi])
      );
   end

   // FSM, raster counters, threshold latch and hit counter.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      thr_d   = thr_q;
      cnt_d   = cnt_q;
      clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SCAN;
               clr     = 1'b1;
            end
         end
         ST_SCAN: begin
            if (start) begin
               clr = 1'b1;
            end else if (xfer) begin
               if (is_hit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
               if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
                  if (y_q == Y_LAST) state_d = ST_FINISH;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (clr) begin
         x_d   = '0;
         y_d   = '0;
         cnt_d = '0;
         thr_d = thresh;
      end
   end

   // Registered outputs: results only move in the cycle leaving FINISH.
   always_comb begin
      busy_d    = (state_d != ST_IDLE);
      ready_d   = (state_d == ST_SCAN);
      done_d    = 1'b0;
      cval_d    = cval_q;
      hcnt_d    = hcnt_q;
      corners_d = corners_q;
      if (state_q == ST_FINISH) begin
         done_d = 1'b1;
         hcnt_d = cnt_q;
         cval_d = (cnt_q >= MIN_CNT);
         for (int i = 0; i < 4; i++) begin
            if (cval_d && trk_seen[i]) begin
               corners_d[(7-2*i)*COORD_W +: COORD_W] = trk_x[i];
               corners_d[(6-2*i)*COORD_W +: COORD_W] = trk_y[i];
            end else begin
               corners_d[(7-2*i)*COORD_W +: COORD_W] = DEF_SET[(7-2*i)*COORD_W +: COORD_W];
               corners_d[(6-2*i)*COORD_W +: COORD_W] = DEF_SET[(6-2*i)*COORD_W +: COORD_W];
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         thr_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         cval_q    <= 1'b0;
         hcnt_q    <= '0;
         corners_q <= DEF_SET;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         thr_q     <= thr_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         cval_q    <= cval_d;
         hcnt_q    <= hcnt_d;
         corners_q <= corners_d;
      end
   end

   assign pix.pix_ready = ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign corners_valid = cval_q;
   assign hit_count     = hcnt_q;
   assign corners       = corners_q;

endmodule

// File: tb/tb_corner_tracker.sv
// Bench for corner_tracker: random backgrounds/gaps against a frame-level reference model.
module tb_corner_tracker;
   localparam int CW = 10;
   localparam int H  = 64;
   localparam int V  = 48;
   localparam int NPIX = H * V;
   localparam int TH = 128;

`ifdef CORNER_FALLBACK_EN
   localparam logic [8*CW-1:0] DEF = {10'd192, 10'd144, 10'd832, 10'd144,
                                      10'd192, 10'd624, 10'd832, 10'd624};
`else
   localparam logic [8*CW-1:0] DEF = '0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [7:0]      thresh = 8'd0;
   logic            busy, done, corners_valid;
   logic [19:0]     hit_count;
   logic [8*CW-1:0] corners;

   corner_tracker_if #(.PIX_W(8)) pif ();

   corner_tracker #(.COORD_W(CW), .H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(8),
                    .MIN_HITS(1), .CNT_W(20)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh), .pix(pif),
      .busy(busy), .done(done), .corners_valid(corners_valid),
      .hit_count(hit_count), .corners(corners));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int frame [NPIX];

   always @(negedge clk) if (done) done_cnt++;

   task automatic clear_frame();
      for (int i = 0; i < NPIX; i++) frame[i] = $urandom_range(0, TH - 1);
   endtask

   task automatic put_hit(input int x, input int y, input int v);
      frame[y*H + x] = v;
   endtask

   // Reference: every corner expressed as "maximise a score", first hit seeds all.
   task automatic model(output logic [8*CW-1:0] c, output int n);
      int bm[4], bx[4], by[4], m[4];
      n = 0;
      for (int k = 0; k < 4; k++) begin bm[k] = 0; bx[k] = 0; by[k] = 0; end
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            if (frame[y*H + x] >= TH) begin
               m[0] = -(x + y); m[1] = x - y; m[2] = y - x; m[3] = x + y;
               for (int k = 0; k < 4; k++)
                  if (n == 0 || m[k] > bm[k]) begin bm[k] = m[k]; bx[k] = x; by[k] = y; end
               n++;
            end
      if (n >= 1)
         c = {CW'(bx[0]), CW'(by[0]), CW'(bx[1]), CW'(by[1]),
              CW'(bx[2]), CW'(by[2]), CW'(bx[3]), CW'(by[3])};
      else
         c = DEF;
   endtask

   task automatic start_scan();
      @(negedge clk);
      pif.pix_valid = 1'b0;
      start = 1'b1;
      thresh = 8'(TH);
      @(negedge clk);
      start = 1'b0;
      thresh = 8'($urandom);   // must have been latched already
   endtask

   // Hand over pixels [0,limit) of frame; returns at the negedge where the last one is offered.
   task automatic send_pixels(input bit gaps, input int limit);
      int i = 0;
      int cyc = 0;
      while (i < limit && cyc < 4*NPIX + 100) begin
         @(negedge clk);
         cyc++;
         if (gaps && $urandom_range(0, 1) == 0) begin
            pif.pix_valid = 1'b0;
            pif.pix_data  = 8'($urandom);
         end else begin
            pif.pix_valid = 1'b1;
            pif.pix_data  = 8'(frame[i]);
            if (pif.pix_ready) i++;
         end
      end
      if (i < limit) begin
         total++; bad++;
         $display("FAIL send_timeout: sent %0d want %0d", i, limit);
      end
   endtask

   // Cycles from the last transfer edge until done is seen (99 if never).
   task automatic finish_frame(output int lat);
      lat = 99;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         pif.pix_valid = 1'b0;
         if (done) begin lat = k + 0; break; end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run_frame(input bit gaps, output int lat, output int pulses);
      int d0;
      d0 = done_cnt;
      start_scan();
      send_pixels(gaps, NPIX);
      finish_frame(lat);
      pulses = done_cnt - d0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pif.pix_valid = 1'b0;
      pif.pix_data = 8'd0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (pif.pix_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", pif.pix_ready); end
      total++; if (corners_valid !== 1'b0) begin bad++; $display("FAIL reset_cval: got %b want 0", corners_valid); end
      total++; if (hit_count !== 20'd0) begin bad++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
      total++; if (corners !== DEF) begin bad++; $display("FAIL reset_corners: got %h want %h", corners, DEF); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      logic [8*CW-1:0] exp; int n, lat, pulses;
      clear_frame(); put_hit(10, 5, 200); model(exp, n);
      run_frame(1'b0, lat, pulses);
      total++; if (lat !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", lat); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", pulses); end
      total++; if (corners !== {4{10'd10, 10'd5}}) begin bad++; $display("FAIL single_corners: got %h want %h", corners, {4{10'd10, 10'd5}}); end
      total++; if (corners !== exp) begin bad++; $display("FAIL single_model: got %h want %h", corners, exp); end
      total++; if (hit_count !== 20'(n)) begin bad++; $display("FAIL single_hits: got %0d want %0d", hit_count, n); end
      total++; if (corners_valid !== 1'b1) begin bad++; $display("FAIL single_cval: got %b want 1", corners_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_four(input bit gaps);
      logic [8*CW-1:0] exp; int n, lat, pulses;
      logic [8*CW-1:0] lit;
      lit = {10'd3, 10'd2, 10'd60, 10'd2, 10'd3, 10'd40, 10'd60, 10'd40};
      clear_frame();
      put_hit(3, 2, 255); put_hit(60, 2, 128); put_hit(3, 40, 180); put_hit(60, 40, 201);
      model(exp, n);
      run_frame(gaps, lat, pulses);
      total++; if (lat !== 2) begin bad++; $display("FAIL four_latency(gaps=%0d): got %0d want 2", gaps, lat); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL four_pulses(gaps=%0d): got %0d want 1", gaps, pulses); end
      total++; if (corners !== lit) begin bad++; $display("FAIL four_corners(gaps=%0d): got %h want %h", gaps, corners, lit); end
      total++; if (corners !== exp) begin bad++; $display("FAIL four_model(gaps=%0d): got %h want %h", gaps, corners, exp); end
      total++; if (hit_count !== 20'd4) begin bad++; $display("FAIL four_hits(gaps=%0d): got %0d want 4", gaps, hit_count); end
   endtask

   task automatic test_empty();
      int lat, pulses;
      clear_frame();
      run_frame(1'b0, lat, pulses);
      total++; if (pulses !== 1) begin bad++; $display("FAIL empty_pulses: got %0d want 1", pulses); end
      total++; if (corners_valid !== 1'b0) begin bad++; $display("FAIL empty_cval: got %b want 0", corners_valid); end
      total++; if (hit_count !== 20'd0) begin bad++; $display("FAIL empty_hits: got %0d want 0", hit_count); end
      total++; if (corners !== DEF) begin bad++; $display("FAIL empty_corners: got %h want %h", corners, DEF); end
   endtask

   task automatic test_tie();
      logic [8*CW-1:0] lit; int lat, pulses;
      lit = {10'd6, 10'd4, 10'd6, 10'd4, 10'd5, 10'd5, 10'd6, 10'd4};
      clear_frame(); put_hit(6, 4, 130); put_hit(5, 5, 250);
      run_frame(1'b0, lat, pulses);
      total++; if (corners !== lit) begin bad++; $display("FAIL tie_corners: got %h want %h", corners, lit); end
      total++; if (hit_count !== 20'd2) begin bad++; $display("FAIL tie_hits: got %0d want 2", hit_count); end
   endtask

   task automatic test_restart();
      logic [8*CW-1:0] prev; int d0, lat;
      prev = {10'd6, 10'd4, 10'd6, 10'd4, 10'd5, 10'd5, 10'd6, 10'd4};
      d0 = done_cnt;
      clear_frame(); put_hit(5, 5, 200); put_hit(1, 1, 200); put_hit(40, 10, 200);
      start_scan();
      send_pixels(1'b0, 1000);
      clear_frame(); put_hit(20, 20, 140);
      @(negedge clk);
      pif.pix_valid = 1'b0;
      start = 1'b1;
      thresh = 8'(TH);
      total++; if (corners !== prev) begin bad++; $display("FAIL restart_hold_corners: got %h want %h", corners, prev); end
      total++; if (hit_count !== 20'd2) begin bad++; $display("FAIL restart_hold_hits: got %0d want 2", hit_count); end
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b want 1", busy); end
      send_pixels(1'b0, NPIX);
      finish_frame(lat);
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL restart_pulses: got %0d want 1", done_cnt - d0); end
      total++; if (corners !== {4{10'd20, 10'd20}}) begin bad++; $display("FAIL restart_corners: got %h want %h", corners, {4{10'd20, 10'd20}}); end
      total++; if (hit_count !== 20'd1) begin bad++; $display("FAIL restart_hits: got %0d want 1", hit_count); end
   endtask

   task automatic test_reset_mid();
      int d0;
      clear_frame(); put_hit(2, 2, 200);
      start_scan();
      send_pixels(1'b1, 500);
      d0 = done_cnt;
      @(negedge clk);
      pif.pix_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      total++; if (pif.pix_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", pif.pix_ready); end
      total++; if (corners !== DEF) begin bad++; $display("FAIL midrst_corners: got %h want %h", corners, DEF); end
      total++; if (hit_count !== 20'd0 || corners_valid !== 1'b0) begin bad++; $display("FAIL midrst_hits: got %0d/%b want 0/0", hit_count, corners_valid); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      total++; if (done_cnt !== d0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_nodone: got done=%0d busy=%b want 0/0", done_cnt - d0, busy); end
   endtask

   task automatic test_random(input int iters);
      logic [8*CW-1:0] exp; int n, lat, pulses;
      for (int it = 0; it < iters; it++) begin
         clear_frame();
         for (int i = 0; i < NPIX; i++)
            if ($urandom_range(0, 199) == 0) frame[i] = $urandom_range(TH, 255);
         model(exp, n);
         run_frame(it[0], lat, pulses);
         total++; if (lat !== 2 || pulses !== 1) begin bad++; $display("FAIL rand%0d_done: got lat=%0d pulses=%0d want 2/1", it, lat, pulses); end
         total++; if (corners !== exp) begin bad++; $display("FAIL rand%0d_corners: got %h want %h", it, corners, exp); end
         total++; if (hit_count !== 20'(n)) begin bad++; $display("FAIL rand%0d_hits: got %0d want %0d", it, hit_count, n); end
         total++; if (corners_valid !== (n >= 1)) begin bad++; $display("FAIL rand%0d_cval: got %b want %b", it, corners_valid, n >= 1); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_four(1'b0);
      test_empty();
      test_tie();
      test_restart();
      test_four(1'b1);
      test_reset_mid();
      test_random(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
